scramble_player: RTL and testbench

Consumes the 32-bit scramble word produced by the board randomizer and turns it into a timed sequence of 16 discrete board moves. It is the receiving end of the randomizer's output: the game controller pulses `start` while the board is in the mix state, and this block issues moves to the board-update logic over a valid/ready handshake. It suppresses immediate back-and-forth moves so the scramble is never trivially self-cancelling.

---
 rtl/scramble_pkg.sv | 31 +++
 rtl/scramble_dir_filter.sv | 15 +
 rtl/scramble_player.sv | 88 ++++++++
 tb/tb_scramble_player.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scramble_pkg.sv
// Shared definitions for the scramble player: move directions, FSM encoding
// and the direction helpers used by the anti-reversal filter.
package scramble_pkg;

    localparam int MOVE_W = 2;

    localparam logic [MOVE_W-1:0] DIR_UP    = 2'b00;
    localparam logic [MOVE_W-1:0] DIR_RIGHT = 2'b01;
    localparam logic [MOVE_W-1:0] DIR_DOWN  = 2'b10;
    localparam logic [MOVE_W-1:0] DIR_LEFT  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Opposite direction: flipping the high bit swaps up/down and right/left.
    function automatic logic [MOVE_W-1:0] reverse_of(input logic [MOVE_W-1:0] d);
        return d ^ DIR_DOWN;
    endfunction

    function automatic logic [MOVE_W-1:0] rotate_cw(input logic [MOVE_W-1:0] d);
        case (d)
            DIR_UP:    return DIR_RIGHT;
            DIR_RIGHT: return DIR_DOWN;
            DIR_DOWN:  return DIR_LEFT;
            default:   return DIR_UP;
        endcase
    endfunction

endpackage

// File: rtl/scramble_dir_filter.sv
// Anti-reversal filter: a move that would undo the previously issued move is
// rotated one step clockwise instead.
module scramble_dir_filter
    import scramble_pkg::*;
(
    input  logic [1:0] raw_dir,
    input  logic [1:0] prev_dir,
    input  logic       prev_vld,
    output logic [1:0] dir_out
);

    assign dir_out = (prev_vld && (raw_dir == reverse_of(prev_dir))) ? rotate_cw(raw_dir)
                                                                     : raw_dir;

endmodule

// File: rtl/scramble_player.sv
// Turns a captured 32-bit scramble word into MOVE_COUNT board moves issued
// over a valid/ready handshake, with an idle gap between accepted moves.
module scramble_player
    import scramble_pkg::*;
#(
    parameter int MOVE_COUNT = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] rand_bits,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [1:0]  move_dir,
    output logic        busy,
    output logic        done,
    output logic [4:0]  moves_issued
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [4:0]       LAST_MOVE = 5'(MOVE_COUNT - 1);

    logic [1:0]       state;
    logic [31:0]      shift_reg;
    logic [1:0]       prev_dir;
    logic             prev_vld;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       filt_dir;
    logic             xfer;

    scramble_dir_filter u_filter (
        .raw_dir  (shift_reg[1:0]),
        .prev_dir (prev_dir),
        .prev_vld (prev_vld),
        .dir_out  (filt_dir)
    );

    assign move_valid = (state == ST_ISSUE);
    assign move_dir   = move_valid ? filt_dir : DIR_UP;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign xfer       = move_valid && move_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            prev_dir     <= DIR_UP;
            prev_vld     <= 1'b0;
            gap_cnt      <= '0;
            moves_issued <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg    <= rand_bits;
                        moves_issued <= '0;
                        prev_vld     <= 1'b0;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer) begin
                        shift_reg    <= shift_reg >> 2;
                        moves_issued <= moves_issued + 5'd1;
                        prev_dir     <= filt_dir;
                        prev_vld     <= 1'b1;
                        gap_cnt      <= '0;
                        if (moves_issued == LAST_MOVE)
                            state <= ST_DONE;
                        else
                            state <= (GAP_CYCLES == 0) ? ST_ISSUE : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= ST_ISSUE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scramble_player.sv
// Scoreboard bench for scramble_player: a reference model pushes expected
// directions per scramble, a monitor pops and compares on every transfer.
module tb_scramble_player;

    localparam int MC  = 16;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst, start, move_ready;
    logic [31:0] rand_bits;
    logic        move_valid, busy, done;
    logic [1:0]  move_dir;
    logic [4:0]  moves_issued;

    logic        start_z, ready_z;
    logic [31:0] rand_z;
    logic        valid_z, busy_z, done_z;
    logic [1:0]  dir_z;
    logic [4:0]  issued_z;

    scramble_player #(.MOVE_COUNT(MC), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .rand_bits(rand_bits),
        .move_valid(move_valid), .move_ready(move_ready), .move_dir(move_dir),
        .busy(busy), .done(done), .moves_issued(moves_issued)
    );

    scramble_player #(.MOVE_COUNT(MC), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .start(start_z), .rand_bits(rand_z),
        .move_valid(valid_z), .move_ready(ready_z), .move_dir(dir_z),
        .busy(busy_z), .done(done_z), .moves_issued(issued_z)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int exp_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int start_cyc = 0;
    int last_xfer = 0;
    bit chk_spacing = 0;
    bit chk_lat = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: move i uses bits [2i+1:2i]; a move equal to the reverse of the
    // previously issued move is replaced by the next direction clockwise.
    task automatic push_model(input logic [31:0] w, inout int q[$]);
        int prev = 0;
        bit pv = 0;
        for (int i = 0; i < MC; i++) begin
            int raw = int'((w >> (2 * i)) & 32'd3);
            int d = (pv && raw == (prev ^ 2)) ? (raw + 1) % 4 : raw;
            q.push_back(d);
            prev = d;
            pv = 1;
        end
    endtask

    task automatic start_scramble(input logic [31:0] w);
        rand_bits = w;
        start = 1'b1;
        push_model(w, exp_q);
        exp_cnt = 0;
        step();
        start_cyc = cyc;
        start = 1'b0;
        rand_bits = $urandom;
        cmp("busy_after_start", int'(busy), 1);
        cmp("valid_after_start", int'(move_valid), 1);
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int base = xfer_cnt;
        for (int i = 0; i < budget && xfer_cnt < base + n; i++) step();
        if (xfer_cnt < base + n) cmp("xfer_timeout", xfer_cnt - base, n);
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        int base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) begin
            if (rnd_ready) move_ready = 1'($urandom_range(0, 1));
            step();
        end
        if (done_cnt == base) cmp("done_timeout", done_cnt - base, 1);
        move_ready = 1'b1;
    endtask

    // Monitor: compare each accepted move against the scoreboard queue.
    initial begin
        bit stall_q = 0;
        int stall_dir = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 0;
            end else begin
                if (stall_q) begin
                    cmp("stall_valid", int'(move_valid), 1);
                    cmp("stall_dir", int'(move_dir), stall_dir);
                end
                if (move_valid) cmp("moves_issued", int'(moves_issued), exp_cnt);
                if (move_valid && move_ready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_move: got dir %0d, expected no move", move_dir);
                    end else begin
                        cmp("move_dir", int'(move_dir), exp_q.pop_front());
                    end
                    if (chk_spacing && exp_cnt > 0) cmp("move_spacing", cyc - last_xfer, GAP + 1);
                    last_xfer = cyc;
                    exp_cnt++;
                    xfer_cnt++;
                end
                if (done) begin
                    cmp("done_moves_issued", int'(moves_issued), MC);
                    cmp("done_queue_left", exp_q.size(), 0);
                    cmp("done_busy", int'(busy), 1);
                    // cyc here is the edge count of the last transfer edge
                    if (chk_lat) cmp("done_latency", cyc - start_cyc, 1 + (MC - 1) * (GAP + 1));
                    done_cnt++;
                end
                stall_q = move_valid && !move_ready;
                stall_dir = int'(move_dir);
            end
        end
    end

    initial begin
        int d0;
        int zq[$];
        rst = 1'b1; start = 1'b0; rand_bits = '0; move_ready = 1'b0;
        start_z = 1'b0; rand_z = '0; ready_z = 1'b1;
        step(); step();
        cmp("rst_busy", int'(busy), 0);
        cmp("rst_valid", int'(move_valid), 0);
        cmp("rst_dir", int'(move_dir), 0);
        cmp("rst_done", int'(done), 0);
        cmp("rst_issued", int'(moves_issued), 0);
        rst = 1'b0;
        step();

        // All up, timing of the full scramble
        move_ready = 1'b1;
        chk_spacing = 1; chk_lat = 1;
        start_scramble(32'h0000_0000);
        wait_done(200, 0);
        cmp("idle_after_done", int'(busy), 0);
        cmp("issued_holds", int'(moves_issued), MC);
        chk_lat = 0;

        // Reversal filter
        start_scramble(32'h0000_0008);
        wait_done(200, 0);
        chk_spacing = 0;

        // Backpressure during the third move
        start_scramble($urandom);
        wait_xfers(2, 50);
        move_ready = 1'b0;
        repeat (GAP + 10) step();
        cmp("bp_issued", int'(moves_issued), 2);
        cmp("bp_valid", int'(move_valid), 1);
        move_ready = 1'b1;
        wait_done(300, 0);

        // Reset mid-scramble, then a fresh scramble
        start_scramble($urandom);
        wait_xfers(7, 100);
        d0 = done_cnt;
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        cmp("mid_rst_busy", int'(busy), 0);
        cmp("mid_rst_valid", int'(move_valid), 0);
        cmp("mid_rst_issued", int'(moves_issued), 0);
        repeat (10) step();
        cmp("mid_rst_no_done", done_cnt, d0);
        start_scramble($urandom);
        wait_done(300, 0);

        // Ignored start while busy
        start_scramble($urandom);
        d0 = done_cnt;
        wait_xfers(3, 50);
        rand_bits = $urandom;
        start = 1'b1;
        step();
        start = 1'b0;
        rand_bits = $urandom;
        wait_done(300, 0);
        repeat (30) step();
        cmp("single_done", done_cnt - d0, 1);

        // Random words with random backpressure
        for (int k = 0; k < 4; k++) begin
            start_scramble($urandom);
            wait_done(1500, 1);
            step();
        end

        // Zero gap: a valid move on every cycle
        push_model(32'hFFFF_FFFF, zq);
        rand_z = 32'hFFFF_FFFF;
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        rand_z = '0;
        for (int i = 0; i < MC; i++) begin
            cmp("zero_gap_valid", int'(valid_z), 1);
            cmp("zero_gap_dir", int'(dir_z), zq.pop_front());
            cmp("zero_gap_issued", int'(issued_z), i);
            step();
        end
        cmp("zero_gap_done", int'(done_z), 1);
        cmp("zero_gap_count", int'(issued_z), MC);
        step();
        cmp("zero_gap_idle", int'(busy_z), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
